wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order writeback stage and a
//   long-latency unit (LLU, e.g. mul/div). Pipeline writes have priority; an LLU result waiting
//   too long forces a one-cycle pipeline stall. A scoreboard of LLU-pending rd's flags RAW/WAW
//   hazards to decode. Sits between writeback/LLU outputs and the register file write port.
// PARAMETERS
//   STARVE_LIMIT  4   cycles an LLU result may wait before stall_o forces an LLU grant (>=1)
//   NREGS         32  architectural registers; rd/rs indices are $clog2(NREGS) bits
// PORTS
//   clk          in   1   clock, all state on posedge
//   rst          in   1   reset: one clock; reset is asynchronous and active-high
//   pipe_we_i    in   1   writeback stage has a result this cycle (no backpressure)
//   pipe_rd_i    in   5   writeback destination
//   pipe_data_i  in   32  writeback data
//   llu_valid_i  in   1   LLU result valid; held stable until llu_ready_o
//   llu_ready_o  out  1   LLU result accepted this cycle (combinational grant)
//   llu_rd_i     in   5   LLU destination
//   llu_data_i   in   32  LLU data
//   issue_i      in   1   decode issues an LLU op this cycle
//   issue_rd_i   in   5   destination of the issued LLU op
//   rs1_i/rs2_i  in   5   decode source indices for hazard query
//   chk_rd_i     in   5   decode destination index for WAW query
//   hazard_o     out  1   rs1/rs2/chk_rd pending in scoreboard (combinational)
//   stall_o      out  1   pipeline must present pipe_we_i=0 in the next cycle
//   rf_we_o      out  1   register-file write enable (registered)
//   rf_rd_o      out  5   register-file write index (registered)
//   rf_data_o    out  32  register-file write data (registered)
// BEHAVIOUR
//   - Reset: rf_we_o=0, rf_rd_o=0, rf_data_o=0, stall_o=0, scoreboard all 0, wait_cnt=0, FSM=IDLE.
//   - Latency: winner captured on posedge, visible on rf_* next cycle (1 cycle).
//   - Grant: llu_ready_o = llu_valid_i & (!pipe_we_i | FSM==FORCE). Pipe wins otherwise.
//   - rd==0: write suppressed (rf_we_o=0) but handshake still completes; x0 never pending.
//   - FSM IDLE: llu_valid_i & !llu_ready_o -> WAIT, wait_cnt=1; granted or no valid -> stay.
//   - FSM WAIT: wait_cnt++ per ungranted cycle; on grant -> IDLE, cnt=0; when wait_cnt reaches
//     STARVE_LIMIT, stall_o=1 (registered) and -> FORCE.
//   - FSM FORCE: pipe_we_i must be 0 (assert if not; LLU still wins, pipe write dropped, error);
//     LLU granted, stall_o->0, -> IDLE. llu_valid_i dropping in WAIT/FORCE is illegal (assert).
//   - Scoreboard: issue_i & issue_rd_i!=0 sets bit; LLU grant clears bit llu_rd_i. Same-rd set
//     and clear in one cycle -> bit stays 1 (new op pending). hazard_o includes bits set this cycle? No:
//     hazard_o reads registered scoreboard only.
//   - Pipe write to a pending rd is illegal (decode stalls on hazard_o); asserted in sim.
//   - Reset mid-wait: pending LLU result is lost; LLU must also be reset by rst.
// CONFIGURATION
//   WB_ARB_BYPASS_EN defined: adds outputs fwd_valid_o(1), fwd_rd_o(5), fwd_data_o(32) =
//     combinational copy of this cycle's winner (before the rf_* register), for decode forwarding;
//     fwd_valid_o=0 when no winner or rd==0.
//   Undefined: ports absent; consumers see results only after rf_* write (1-cycle later).
// TESTING
//   1. pipe_we=1 rd=5 data=0xDEAD_BEEF, no LLU -> next cycle rf_we=1 rf_rd=5 rf_data=0xDEADBEEF.
//   2. pipe_we=0, llu_valid rd=7 data=0x1234 -> llu_ready same cycle; rf_rd=7 data=0x1234 next.
//   3. pipe_we=1 every cycle, llu_valid rd=9 -> stall_o=1 after 4 waiting cycles; LLU granted in
//      the stall bubble, rf_rd=9 written; stall_o=0 after.
//   4. issue_i rd=3, then rs1_i=3 -> hazard_o=1; LLU completes rd=3 -> hazard_o=0 next cycle.
//   5. llu rd=0 data=0xFFFF -> llu_ready=1, rf_we_o=0; issue rd=0 -> hazard_o stays 0.
//   6. rst pulsed mid-WAIT (cnt=2) -> all outputs 0, FSM IDLE, scoreboard cleared immediately.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a long-latency unit, with an LLU scoreboard.
// Defining WB_ARB_BYPASS_EN adds fwd_valid_o/fwd_rd_o/fwd_data_o (combinational copy of this cycle's winner).
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int NREGS = 32,
  localparam int RW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we_i,
  input  logic [RW-1:0] pipe_rd_i,
  input  logic [31:0]   pipe_data_i,
  input  logic          llu_valid_i,
  output logic          llu_ready_o,
  input  logic [RW-1:0] llu_rd_i,
  input  logic [31:0]   llu_data_i,
  input  logic          issue_i,
  input  logic [RW-1:0] issue_rd_i,
  input  logic [RW-1:0] rs1_i,
  input  logic [RW-1:0] rs2_i,
  input  logic [RW-1:0] chk_rd_i,
  output logic          hazard_o,
  output logic          stall_o,
  output logic          rf_we_o,
  output logic [RW-1:0] rf_rd_o,
  output logic [31:0]   rf_data_o
`ifdef WB_ARB_BYPASS_EN
  ,
  output logic          fwd_valid_o,
  output logic [RW-1:0] fwd_rd_o,
  output logic [31:0]   fwd_data_o
`endif
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t state;
  logic [CW-1:0] wait_cnt, cnt_n;
  logic [NREGS-1:0] sb, sb_set, sb_clr;
  logic win;
  logic [RW-1:0] win_rd;
  logic [31:0] win_data;
  assign llu_ready_o = llu_valid_i & (!pipe_we_i | state == FORCE);
  assign win = llu_ready_o | pipe_we_i;
  assign win_rd = llu_ready_o ? llu_rd_i : pipe_rd_i;
  assign win_data = llu_ready_o ? llu_data_i : pipe_data_i;
  assign sb_set = (issue_i && issue_rd_i != '0) ? {{(NREGS-1){1'b0}}, 1'b1} << issue_rd_i : '0;
  assign sb_clr = llu_ready_o ? {{(NREGS-1){1'b0}}, 1'b1} << llu_rd_i : '0;
  assign hazard_o = sb[rs1_i] | sb[rs2_i] | sb[chk_rd_i];
  assign cnt_n = (state == IDLE) ? CW'(1) : wait_cnt + 1'b1;
`ifdef WB_ARB_BYPASS_EN
  assign fwd_valid_o = win && win_rd != '0;
  assign fwd_rd_o = win_rd;
  assign fwd_data_o = win_data;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
      stall_o <= 1'b0;
      sb <= '0;
      rf_we_o <= 1'b0;
      rf_rd_o <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o <= win && win_rd != '0;
      rf_rd_o <= win_rd;
      rf_data_o <= win_data;
      // a set wins over a same-cycle clear: the newly issued op is still pending
      sb <= (sb & ~sb_clr) | sb_set;
      stall_o <= 1'b0;
      if (state == FORCE || llu_ready_o || !llu_valid_i) begin
        state <= IDLE;
        wait_cnt <= '0;
      end else if (cnt_n >= CW'(STARVE_LIMIT)) begin
        state <= FORCE;
        wait_cnt <= cnt_n;
        stall_o <= 1'b1;
      end else begin
        state <= WAIT;
        wait_cnt <= cnt_n;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(state == FORCE && pipe_we_i));
      assert (!(state != IDLE && !llu_valid_i));
      assert (!(pipe_we_i && sb[pipe_rd_i]));
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic against a set-based reference model.
module tb_wb_port_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_we = 0, llu_valid = 0, issue = 0;
  logic [4:0] pipe_rd = 0, llu_rd = 0, issue_rd = 0, rs1 = 0, rs2 = 0, chk_rd = 0;
  logic [31:0] pipe_data = 0, llu_data = 0;
  logic llu_ready, hazard, stall, rf_we;
  logic [4:0] rf_rd;
  logic [31:0] rf_data;
  int errors = 0, checks = 0;
  logic [31:0] m_sb = 0;
  int m_wait = 0;
  logic m_stall = 0, m_we = 0;
  logic [4:0] m_rd;
  logic [31:0] m_data;
  logic e_ready, e_hz, o_ready, o_hz;

  wb_port_arbiter #(.STARVE_LIMIT(LIM), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_data_i(pipe_data),
    .llu_valid_i(llu_valid), .llu_ready_o(llu_ready), .llu_rd_i(llu_rd), .llu_data_i(llu_data),
    .issue_i(issue), .issue_rd_i(issue_rd), .rs1_i(rs1), .rs2_i(rs2), .chk_rd_i(chk_rd),
    .hazard_o(hazard), .stall_o(stall), .rf_we_o(rf_we), .rf_rd_o(rf_rd), .rf_data_o(rf_data));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset;
    m_sb = 0; m_wait = 0; m_stall = 0; m_we = 0;
  endtask

  // sample combinational outputs mid-cycle, advance the model and the clock
  task automatic tick;
    #1;
    e_ready = llu_valid & (!pipe_we | m_stall);
    e_hz = m_sb[rs1] | m_sb[rs2] | m_sb[chk_rd];
    o_ready = llu_ready;
    o_hz = hazard;
    m_we = e_ready ? (llu_rd != 0) : (pipe_we && pipe_rd != 0);
    m_rd = e_ready ? llu_rd : pipe_rd;
    m_data = e_ready ? llu_data : pipe_data;
    if (e_ready) m_sb[llu_rd] = 1'b0;
    if (issue && issue_rd != 0) m_sb[issue_rd] = 1'b1;
    m_wait = (llu_valid && !e_ready) ? m_wait + 1 : 0;
    m_stall = (m_wait == LIM);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if (rf_rd !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL reset_rf: got rd=%0d data=%h want 0", rf_rd, rf_data); end
    checks++; if (stall !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL reset_flags: got stall=%b hazard=%b want 0", stall, hazard); end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_pipe_write;
    pipe_we = 1; pipe_rd = 5; pipe_data = 32'hDEAD_BEEF;
    tick();
    pipe_we = 0;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL pipe_ready: got %b want 0", o_ready); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_write: got we=%b rd=%0d data=%h want 1/5/deadbeef", rf_we, rf_rd, rf_data); end
  endtask

  task automatic test_llu_write;
    llu_valid = 1; llu_rd = 7; llu_data = 32'h1234;
    tick();
    llu_valid = 0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL llu_ready: got %b want 1", o_ready); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h1234) begin errors++; $display("FAIL llu_write: got we=%b rd=%0d data=%h want 1/7/1234", rf_we, rf_rd, rf_data); end
  endtask

  task automatic starve_to_stall(input logic [4:0] rd, output int n);
    pipe_we = 1; pipe_rd = 1; llu_valid = 1; llu_rd = rd; llu_data = 32'hCAFE_0000 | rd;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      pipe_data = i;
      tick();
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL starve_ready: cycle %0d got %b want 0", i, o_ready); end
      checks++; if (rf_rd !== 5'd1 || rf_data !== i) begin errors++; $display("FAIL starve_pipe: got rd=%0d data=%h want 1/%h", rf_rd, rf_data, i); end
      if (stall === 1'b1) begin n = i; break; end
    end
    pipe_we = 0;
  endtask

  task automatic finish_force(input logic [4:0] rd);
    tick();
    llu_valid = 0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL force_ready: got %b want 1", o_ready); end
    checks++; if (rf_we !== 1'b1 || rf_rd !== rd) begin errors++; $display("FAIL force_write: got we=%b rd=%0d want 1/%0d", rf_we, rf_rd, rd); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL force_stall_clear: got %b want 0", stall); end
  endtask

  task automatic test_starve;
    int n;
    starve_to_stall(9, n);
    checks++; if (n != LIM) begin errors++; $display("FAIL starve_cycles: got %0d want %0d", n, LIM); end
    finish_force(9);
  endtask

  task automatic test_scoreboard;
    issue = 1; issue_rd = 3;
    tick();
    issue = 0; rs1 = 3;
    tick();
    checks++; if (o_hz !== 1'b1) begin errors++; $display("FAIL hz_rs1: got %b want 1", o_hz); end
    rs1 = 0; rs2 = 3;
    tick();
    checks++; if (o_hz !== 1'b1) begin errors++; $display("FAIL hz_rs2: got %b want 1", o_hz); end
    rs2 = 0; chk_rd = 3; llu_valid = 1; llu_rd = 3;
    tick();
    llu_valid = 0;
    checks++; if (o_hz !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL hz_chk: got hz=%b ready=%b want 1/1", o_hz, o_ready); end
    chk_rd = 0; rs1 = 3;
    tick();
    checks++; if (o_hz !== 1'b0) begin errors++; $display("FAIL hz_cleared: got %b want 0", o_hz); end
    issue = 1; issue_rd = 3;
    tick();
    llu_valid = 1; llu_rd = 3;
    tick();
    issue = 0; llu_valid = 0;
    tick();
    checks++; if (o_hz !== 1'b1) begin errors++; $display("FAIL hz_set_wins: got %b want 1", o_hz); end
    llu_valid = 1;
    tick();
    llu_valid = 0;
    tick();
    rs1 = 0;
    checks++; if (o_hz !== 1'b0) begin errors++; $display("FAIL hz_final_clear: got %b want 0", o_hz); end
  endtask

  task automatic test_x0;
    llu_valid = 1; llu_rd = 0; llu_data = 32'hFFFF;
    tick();
    llu_valid = 0;
    checks++; if (o_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL x0_llu: got ready=%b we=%b want 1/0", o_ready, rf_we); end
    issue = 1; issue_rd = 0;
    tick();
    issue = 0; rs1 = 0;
    tick();
    checks++; if (o_hz !== 1'b0) begin errors++; $display("FAIL x0_hazard: got %b want 0", o_hz); end
  endtask

  task automatic test_reset_mid_wait;
    int n;
    issue = 1; issue_rd = 12;
    tick();
    issue = 0; pipe_we = 1; pipe_rd = 2; llu_valid = 1; llu_rd = 10;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    rs1 = 12;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin errors++; $display("FAIL midrst_rf: got we=%b rd=%0d data=%h want 0", rf_we, rf_rd, rf_data); end
    checks++; if (stall !== 1'b0 || hazard !== 1'b0) begin errors++; $display("FAIL midrst_flags: got stall=%b hazard=%b want 0", stall, hazard); end
    pipe_we = 0; llu_valid = 0; rs1 = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    starve_to_stall(11, n);
    checks++; if (n != LIM) begin errors++; $display("FAIL midrst_fsm_idle: stall after %0d want %0d", n, LIM); end
    finish_force(11);
  endtask

  task automatic test_random;
    llu_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!llu_valid || e_ready) begin
        llu_valid = ($urandom % 3) == 0;
        llu_rd = 5'($urandom);
        llu_data = $urandom;
      end
      pipe_we = m_stall ? 1'b0 : (($urandom % 4) != 0);
      pipe_rd = 5'($urandom);
      if (m_sb[pipe_rd]) pipe_rd = 0;
      pipe_data = $urandom;
      issue = ($urandom % 3) == 0;
      issue_rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom); chk_rd = 5'($urandom);
      tick();
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b want %b", i, o_ready, e_ready); end
      checks++; if (o_hz !== e_hz) begin errors++; $display("FAIL rnd_hazard: cycle %0d got %b want %b", i, o_hz, e_hz); end
      checks++; if (stall !== m_stall) begin errors++; $display("FAIL rnd_stall: cycle %0d got %b want %b", i, stall, m_stall); end
      checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we: cycle %0d got %b want %b", i, rf_we, m_we); end
      if (m_we) begin
        checks++; if (rf_rd !== m_rd || rf_data !== m_data) begin errors++; $display("FAIL rnd_rf: cycle %0d got %0d/%h want %0d/%h", i, rf_rd, rf_data, m_rd, m_data); end
      end
    end
    pipe_we = 0; issue = 0;
    while (llu_valid && !e_ready) tick();
    llu_valid = 0;
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_llu_write();
    test_starve();
    test_scoreboard();
    test_x0();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
